cache_controller: RTL and testbench

Two-level (L2/L3) data cache controller with dynamic line migration. Writes are stored into a direct-mapped L3 array. Reads that hit L3 return the data and also copy the line into a small fully-associative L2 with LRU replacement, so later reads of that line are served from L2. It sits between a single requester and the on-chip data store, with one registered read/write port.

---
 rtl/cache_controller.sv | 156 +++++++++++++++
 tb/tb_cache_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: two-level data cache with a direct-mapped L3 backing array
// and a small fully-associative L2 managed by true LRU ages. L3 hits migrate
// the line into L2 so that repeated reads are served from L2. The L3 stays
// inclusive, and writes keep any resident L2 copy coherent.
// Optional build macro CACHE_STATS_EN adds saturating 16-bit hit/miss counters.
module cache_controller #(
  parameter int CACHE_SIZE = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int L2_ENTRIES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  hit
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           l2_hit_cnt,
  output logic [15:0]           l3_hit_cnt,
  output logic [15:0]           miss_cnt
`endif
);

  localparam int AGE_W = $clog2(L2_ENTRIES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(L2_ENTRIES - 1);

  logic                  l3_valid [CACHE_SIZE];
  logic [DATA_WIDTH-1:0] l3_data  [CACHE_SIZE];

  logic                  l2_valid [L2_ENTRIES];
  logic [ADDR_WIDTH-1:0] l2_tag   [L2_ENTRIES];
  logic [DATA_WIDTH-1:0] l2_data  [L2_ENTRIES];
  logic [AGE_W-1:0]      l2_age   [L2_ENTRIES];

  logic             l2_hit;
  logic [AGE_W-1:0] l2_hit_idx;
  logic             have_invalid;
  logic [AGE_W-1:0] victim_idx;
  logic [AGE_W-1:0] max_age;
  logic             l3_hit;
  logic             do_read;
  logic             fill_en;
  logic             touch_en;
  logic [AGE_W-1:0] touch_idx;
  logic [AGE_W-1:0] touch_old_age;

  // L2 lookup, victim selection and the LRU touch target for this request
  always_comb begin
    l2_hit       = 1'b0;
    l2_hit_idx   = '0;
    have_invalid = 1'b0;
    victim_idx   = '0;
    max_age      = '0;
    for (int i = 0; i < L2_ENTRIES; i++) begin
      if (l2_valid[i] && (l2_tag[i] == addr) && !l2_hit) begin
        l2_hit     = 1'b1;
        l2_hit_idx = AGE_W'(i);
      end
    end
    for (int i = 0; i < L2_ENTRIES; i++) begin
      if (!l2_valid[i] && !have_invalid) begin
        have_invalid = 1'b1;
        victim_idx   = AGE_W'(i);
      end
    end
    if (!have_invalid) begin
      for (int i = 0; i < L2_ENTRIES; i++) begin
        if (l2_age[i] > max_age) begin
          max_age    = l2_age[i];
          victim_idx = AGE_W'(i);
        end
      end
    end
    l3_hit   = l3_valid[addr];
    do_read  = rd_en && !wr_en;
    fill_en  = do_read && !l2_hit && l3_hit;
    touch_en = (wr_en && l2_hit) || (do_read && (l2_hit || l3_hit));
    if (l2_hit) begin
      touch_idx     = l2_hit_idx;
      touch_old_age = l2_age[l2_hit_idx];
    end else begin
      touch_idx     = victim_idx;
      touch_old_age = l2_valid[victim_idx] ? l2_age[victim_idx] : AGE_MAX;
    end
  end

  // L3 data array carries no reset; its valid bits decide whether data counts
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      l3_data[addr] <= data_in;
    end
  end

  // Request handling: L3/L2 state, migration, LRU ages and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CACHE_SIZE; i++) l3_valid[i] <= 1'b0;
      for (int i = 0; i < L2_ENTRIES; i++) begin
        l2_valid[i] <= 1'b0;
        l2_age[i]   <= '0;
      end
      data_out <= '0;
      hit      <= 1'b0;
`ifdef CACHE_STATS_EN
      l2_hit_cnt <= '0;
      l3_hit_cnt <= '0;
      miss_cnt   <= '0;
`endif
    end else begin
      if (wr_en) begin
        l3_valid[addr] <= 1'b1;
        if (l2_hit) l2_data[l2_hit_idx] <= data_in;
        hit <= 1'b0;
      end else if (rd_en) begin
        if (l2_hit) begin
          data_out <= l2_data[l2_hit_idx];
          hit      <= 1'b1;
`ifdef CACHE_STATS_EN
          if (l2_hit_cnt != 16'hFFFF) l2_hit_cnt <= l2_hit_cnt + 16'd1;
`endif
        end else if (l3_hit) begin
          data_out <= l3_data[addr];
          hit      <= 1'b1;
`ifdef CACHE_STATS_EN
          if (l3_hit_cnt != 16'hFFFF) l3_hit_cnt <= l3_hit_cnt + 16'd1;
`endif
        end else begin
          data_out <= '0;
          hit      <= 1'b0;
`ifdef CACHE_STATS_EN
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
`endif
        end
      end
      if (fill_en) begin
        l2_valid[victim_idx] <= 1'b1;
        l2_tag[victim_idx]   <= addr;
        l2_data[victim_idx]  <= l3_data[addr];
      end
      if (touch_en) begin
        for (int i = 0; i < L2_ENTRIES; i++) begin
          if (AGE_W'(i) == touch_idx) begin
            l2_age[i] <= '0;
          end else if (l2_valid[i] && (l2_age[i] < touch_old_age)) begin
            l2_age[i] <= l2_age[i] + AGE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed self-checking bench for cache_controller.
// Stat counter checks are active only when CACHE_STATS_EN is defined.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;
`ifdef CACHE_STATS_EN
  logic [15:0] l2_hit_cnt;
  logic [15:0] l3_hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  cache_controller #(
    .CACHE_SIZE(256),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .L2_ENTRIES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .hit(hit)
`ifdef CACHE_STATS_EN
    ,
    .l2_hit_cnt(l2_hit_cnt),
    .l3_hit_cnt(l3_hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  // 10-unit free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request between edges, then settle just past the capturing edge
  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_data, input logic exp_hit);
    checkVal({tag, ".data"}, data_out, exp_data);
    checkVal({tag, ".hit"}, {31'd0, hit}, {31'd0, exp_hit});
  endtask

  task automatic checkStats(input string tag, input int exp_l2, input int exp_l3, input int exp_miss);
`ifdef CACHE_STATS_EN
    checkVal({tag, ".l2"},   {16'd0, l2_hit_cnt}, exp_l2);
    checkVal({tag, ".l3"},   {16'd0, l3_hit_cnt}, exp_l3);
    checkVal({tag, ".miss"}, {16'd0, miss_cnt},   exp_miss);
`else
    if (exp_l2 < 0 || exp_l3 < 0 || exp_miss < 0) $display("[TB] bad stats argument in %s", tag);
`endif
  endtask

  // Directed sequence; expected values are worked out by hand per step
  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; data_in = '0;

    // Phase A: reset, miss, migrate, L2 hit, idle hold
    applyStimulus(1, 0, 0, 8'h00, 32'h0);
    checkOutput("reset", 32'h0, 1'b0);
    checkStats("reset", 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h10, 32'h0);
    checkOutput("miss10", 32'h0, 1'b0);
    checkStats("miss10", 0, 0, 1);
    applyStimulus(0, 1, 0, 8'hAA, 32'hDEAD);
    checkOutput("wrAA", 32'h0, 1'b0);
    applyStimulus(0, 0, 1, 8'hAA, 32'h0);
    checkOutput("rdAA_l3", 32'hDEAD, 1'b1);
    applyStimulus(0, 0, 1, 8'hAA, 32'h0);
    checkOutput("rdAA_l2", 32'hDEAD, 1'b1);
    checkStats("rdAA", 1, 1, 1);
    applyStimulus(0, 0, 0, 8'h33, 32'h1234);
    checkOutput("idle", 32'hDEAD, 1'b1);
    applyStimulus(0, 1, 0, 8'hBB, 32'hCAFE);
    checkOutput("wrBB", 32'hDEAD, 1'b0);
    applyStimulus(0, 0, 1, 8'hBB, 32'h0);
    checkOutput("rdBB1", 32'hCAFE, 1'b1);
    applyStimulus(0, 0, 1, 8'hBB, 32'h0);
    checkOutput("rdBB2", 32'hCAFE, 1'b1);
    applyStimulus(0, 0, 1, 8'hAA, 32'h0);
    checkOutput("rdAA_again", 32'hDEAD, 1'b1);
    checkStats("phaseA", 3, 2, 1);

    // Phase B: fill L2 with 0x01..0x04, refresh 0x01, 0x05 evicts 0x02
    applyStimulus(1, 0, 0, 8'h00, 32'h0);
    checkStats("resetB", 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, 8'(i), 32'h100 + i);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 8'(i), 32'h0);
    checkOutput("rd04", 32'h104, 1'b1);
    applyStimulus(0, 0, 1, 8'h01, 32'h0);
    checkOutput("rd01_l2", 32'h101, 1'b1);
    checkStats("fill", 1, 4, 0);
    applyStimulus(0, 0, 1, 8'h05, 32'h0);
    checkOutput("rd05_l3", 32'h105, 1'b1);
    checkStats("evict", 1, 5, 0);
    applyStimulus(0, 0, 1, 8'h02, 32'h0);
    checkOutput("rd02_l3", 32'h102, 1'b1);
    checkStats("remigrate02", 1, 6, 0);
    applyStimulus(0, 0, 1, 8'h01, 32'h0);
    checkOutput("rd01_still", 32'h101, 1'b1);
    checkStats("still01", 2, 6, 0);

    // Phase C: write to a line resident in L2 keeps the L2 copy coherent
    applyStimulus(0, 1, 0, 8'h20, 32'h1111);
    applyStimulus(0, 0, 1, 8'h20, 32'h0);
    applyStimulus(0, 0, 1, 8'h20, 32'h0);
    checkOutput("rd20", 32'h1111, 1'b1);
    applyStimulus(0, 1, 0, 8'h20, 32'h2222);
    checkOutput("wr20", 32'h1111, 1'b0);
    applyStimulus(0, 0, 1, 8'h20, 32'h0);
    checkOutput("rd20_new", 32'h2222, 1'b1);
    checkStats("coherent", 4, 7, 0);

    // Phase D: simultaneous write/read, then reset overriding a read
    applyStimulus(0, 1, 1, 8'h30, 32'h55);
    checkOutput("wrrd30", 32'h2222, 1'b0);
    applyStimulus(0, 0, 1, 8'h30, 32'h0);
    checkOutput("rd30", 32'h55, 1'b1);
    checkStats("rd30", 4, 8, 0);
    applyStimulus(1, 0, 1, 8'h30, 32'h0);
    checkOutput("rst_rd", 32'h0, 1'b0);
    checkStats("rst_rd", 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h30, 32'h0);
    checkOutput("rd30_after_rst", 32'h0, 1'b0);
    checkStats("after_rst", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
